// File: rtl/mean_update.sv
// rtl/mean_update.sv - merges two-engine cluster sums/counts and divides them into new 24-bit cluster means
// Optional MEAN_ROUND_EN: round-to-nearest (ties up) instead of truncating floor division.
module mean_update #(
  parameter int T = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [72*T*2-1:0] accumolator,
  input  logic [12*T*2-1:0] counters,
  input  logic [24*T-1:0]   meanIn,
  input  logic [T-1:0]      enabled,
  output logic [24*T-1:0]   meanOut,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [2:0]        i_q, i_d;
  logic [12:0]       cnt_q, cnt_d;
  logic [2:0][25:0]  rem_q, rem_d;
  logic [2:0][7:0]   quo_q, quo_d;
  logic [2:0]        sat_q, sat_d;
  logic [23:0]       prev_q, prev_d;
  logic              keep_q, keep_d;
  logic [24*T-1:0]   mean_q, mean_d;

  logic [71:0]       ac0, ac1;
  logic [11:0]       c0, c1;
  logic [12:0]       cnt_m;
  logic [2:0][25:0]  sum_m;
  logic [25:0]       div_sub;
  logic [2:0][7:0]   result;
  logic              skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      sat_q   <= '0;
      prev_q  <= '0;
      keep_q  <= 1'b0;
      mean_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      sat_q   <= sat_d;
      prev_q  <= prev_d;
      keep_q  <= keep_d;
      mean_q  <= mean_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sat_d   = sat_q;
    prev_d  = prev_q;
    keep_d  = keep_q;
    mean_d  = mean_q;

    ac0   = accumolator[int'(k_q)*72 +: 72];
    ac1   = accumolator[(T+int'(k_q))*72 +: 72];
    c0    = counters[int'(k_q)*12 +: 12];
    c1    = counters[(T+int'(k_q))*12 +: 12];
    cnt_m = 13'(c0) + 13'(c1);
    skip  = ~enabled[k_q] | (cnt_m == 13'd0);

    // 26 bits leaves headroom for the rounding bias on top of a 25-bit merged sum
    for (int ch = 0; ch < 3; ch++) begin
      sum_m[ch] = 26'(ac0[ch*24 +: 24]) + 26'(ac1[ch*24 +: 24]);
`ifdef MEAN_ROUND_EN
      sum_m[ch] = sum_m[ch] + 26'(cnt_m >> 1);
`endif
      result[ch] = sat_q[ch] ? 8'hFF : quo_q[ch];
    end

    div_sub = 26'(cnt_q) << i_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end

      S_LOAD: begin
        cnt_d  = cnt_m;
        prev_d = meanIn[int'(k_q)*24 +: 24];
        quo_d  = '0;
        i_d    = 3'd7;
        keep_d = skip;
        for (int ch = 0; ch < 3; ch++) begin
          rem_d[ch] = sum_m[ch];
          // quotient would not fit in 8 bits; the divider result is overridden with 255
          sat_d[ch] = (sum_m[ch] >= {5'd0, cnt_m, 8'd0});
        end
        state_d = skip ? S_STORE : S_DIV;
      end

      S_DIV: begin
        for (int ch = 0; ch < 3; ch++) begin
          if (rem_q[ch] >= div_sub) begin
            rem_d[ch]      = rem_q[ch] - div_sub;
            quo_d[ch][i_q] = 1'b1;
          end
        end
        if (i_q == 3'd0) begin
          state_d = S_STORE;
        end else begin
          i_d = i_q - 3'd1;
        end
      end

      S_STORE: begin
        mean_d[int'(k_q)*24 +: 24] = keep_q ? prev_q : result;
        if (k_q == 4'(T-1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign meanOut = mean_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_mean_update.sv
// tb/tb_mean_update.sv - directed self-checking bench for mean_update
// Expected values follow MEAN_ROUND_EN when the macro is defined.
module tb_mean_update;
  localparam int T     = 16;
  localparam int LIMIT = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [72*T*2-1:0] accumolator = '0;
  logic [12*T*2-1:0] counters = '0;
  logic [24*T-1:0]   meanIn = '0;
  logic [T-1:0]      enabled = '0;
  logic [24*T-1:0]   meanOut;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  logic [24*T-1:0] exp_full;
  logic [24*T-1:0] rst_mean;
  logic            rst_busy, rst_done;
  logic [23:0]     snap10, snap11;

  mean_update #(.T(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumolator(accumolator),
    .counters   (counters),
    .meanIn     (meanIn),
    .enabled    (enabled),
    .meanOut    (meanOut),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_q(input int unsigned s, input int unsigned c);
    int unsigned v;
    v = s;
`ifdef MEAN_ROUND_EN
    v = v + c / 2;
`endif
    if (v >= 256 * c) return 8'hFF;
    return 8'(v / c);
  endfunction

  task automatic clear_inputs();
    accumolator = '0;
    counters    = '0;
    meanIn      = '0;
    enabled     = '0;
  endtask

  task automatic set_cluster(input int e, input int k, input int r, input int g, input int b, input int c);
    accumolator[(e*T+k)*72 +: 72] = {24'(r), 24'(g), 24'(b)};
    counters[(e*T+k)*12 +: 12]    = 12'(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with the block in IDLE; edge n=1 is the edge that samples start.
  task automatic run(input int start_again, input int reset_at, input bit start_in_done,
                     input int extra, output int done_edge, output int busy_cnt, output int done_cnt);
    int n;
    done_edge = -1;
    busy_cnt  = 0;
    done_cnt  = 0;
    n         = 0;
    start     = 1'b1;
    while (n < LIMIT) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == start_again - 1);
      if (n == reset_at - 1) reset = 1'b1;
      if (n == reset_at) begin
        rst_mean = meanOut;
        rst_busy = busy;
        rst_done = done;
        reset    = 1'b0;
        break;
      end
      if (n == 10) snap10 = meanOut[23:0];
      if (n == 11) snap11 = meanOut[23:0];
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = n;
          if (start_in_done) start = 1'b1;
        end
      end
      if (done_edge >= 0 && n >= done_edge + extra) break;
    end
    start = 1'b0;
  endtask

  task automatic setup_full();
    int unsigned c0, c1, c, tot, a0;
    int unsigned ch_v[3];
    clear_inputs();
    enabled = '1;
    for (int k = 0; k < T; k++) begin
      meanIn[k*24 +: 24] = 24'($urandom);
      c0 = $urandom_range(2047, 1);
      c1 = $urandom_range(2047, 0);
      c  = c0 + c1;
      counters[k*12 +: 12]     = 12'(c0);
      counters[(T+k)*12 +: 12] = 12'(c1);
      for (int ch = 0; ch < 3; ch++) begin
        tot = $urandom_range(256*c - 1, c);
        a0  = $urandom_range(tot, 0);
        accumolator[k*72 + ch*24 +: 24]     = 24'(a0);
        accumolator[(T+k)*72 + ch*24 +: 24] = 24'(tot - a0);
        ch_v[ch] = tot;
        exp_full[k*24 + ch*8 +: 8] = ref_q(tot, c);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (meanOut !== '0) begin miscompares++; $display("FAIL reset_meanOut got %h want 0", meanOut); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_divide();
    int de, bc, dc;
    clear_inputs();
    for (int k = 0; k < T; k++) meanIn[k*24 +: 24] = 24'h010101 * 24'(k + 1);
    enabled[0] = 1'b1;
    set_cluster(0, 0, 300, 600, 900, 3);
    run(-10, -10, 1'b0, 0, de, bc, dc);
    vectors++;
    if (meanOut[23:0] !== 24'h64C8FF) begin miscompares++; $display("FAIL basic_slice0 got %h want 64c8ff", meanOut[23:0]); end
    vectors++;
    if (meanOut[24*T-1:24] !== meanIn[24*T-1:24]) begin
      miscompares++; $display("FAIL basic_disabled_slices got %h want %h", meanOut[24*T-1:24], meanIn[24*T-1:24]);
    end
    vectors++;
    if (de !== 41) begin miscompares++; $display("FAIL basic_done_edge got %0d want 41", de); end
    vectors++;
    if (bc !== 41) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 41", bc); end
    idle(2);
  endtask

  task automatic test_merge();
    int de, bc, dc;
    logic [23:0] want;
`ifdef MEAN_ROUND_EN
    want = {8'd11, 8'd5, 8'd0};
`else
    want = {8'd10, 8'd4, 8'd0};
`endif
    clear_inputs();
    enabled[0] = 1'b1;
    set_cluster(0, 0, 10, 5, 0, 1);
    set_cluster(1, 0, 11, 4, 0, 1);
    run(-10, -10, 1'b0, 0, de, bc, dc);
    vectors++;
    if (meanOut[23:0] !== want) begin miscompares++; $display("FAIL merge_slice0 got %h want %h", meanOut[23:0], want); end
    vectors++;
    if (de !== 41) begin miscompares++; $display("FAIL merge_done_edge got %0d want 41", de); end
    idle(2);
  endtask

  task automatic test_skip();
    int de, bc, dc;
    clear_inputs();
    meanIn[3*24 +: 24] = 24'h123456;
    meanIn[5*24 +: 24] = 24'hABCDEF;
    enabled[0] = 1'b1;
    enabled[3] = 1'b1;
    set_cluster(0, 0, 30, 60, 90, 3);
    set_cluster(0, 5, 500, 500, 500, 2);
    set_cluster(1, 5, 500, 500, 500, 2);
    run(-10, -10, 1'b0, 0, de, bc, dc);
    vectors++;
    if (meanOut[3*24 +: 24] !== 24'h123456) begin miscompares++; $display("FAIL skip_empty got %h want 123456", meanOut[3*24 +: 24]); end
    vectors++;
    if (meanOut[5*24 +: 24] !== 24'hABCDEF) begin miscompares++; $display("FAIL skip_disabled got %h want abcdef", meanOut[5*24 +: 24]); end
    vectors++;
    if (meanOut[23:0] !== 24'h0A141E) begin miscompares++; $display("FAIL skip_active got %h want 0a141e", meanOut[23:0]); end
    vectors++;
    if (de !== 41) begin miscompares++; $display("FAIL skip_done_edge got %0d want 41", de); end
    idle(2);
    enabled[0] = 1'b0;
    run(-10, -10, 1'b0, 0, de, bc, dc);
    vectors++;
    if (de !== 33) begin miscompares++; $display("FAIL skip_all_done_edge got %0d want 33", de); end
    idle(2);
  endtask

  task automatic test_full_load();
    int de, bc, dc;
    setup_full();
    run(-10, -10, 1'b0, 0, de, bc, dc);
    for (int k = 0; k < T; k++) begin
      vectors++;
      if (meanOut[k*24 +: 24] !== exp_full[k*24 +: 24]) begin
        miscompares++; $display("FAIL full_slice%0d got %h want %h", k, meanOut[k*24 +: 24], exp_full[k*24 +: 24]);
      end
    end
    vectors++;
    if (de !== 161) begin miscompares++; $display("FAIL full_done_edge got %0d want 161", de); end
    vectors++;
    if (bc !== 161) begin miscompares++; $display("FAIL full_busy_cycles got %0d want 161", bc); end
    idle(2);
  endtask

  task automatic test_start_during_busy();
    int de, bc, dc;
    setup_full();
    run(50, -10, 1'b1, 4, de, bc, dc);
    vectors++;
    if (dc !== 1) begin miscompares++; $display("FAIL busy_start_done_pulses got %0d want 1", dc); end
    vectors++;
    if (de !== 161) begin miscompares++; $display("FAIL busy_start_done_edge got %0d want 161", de); end
    vectors++;
    if (bc !== 161) begin miscompares++; $display("FAIL busy_start_busy_cycles got %0d want 161", bc); end
    vectors++;
    if (meanOut !== exp_full) begin miscompares++; $display("FAIL busy_start_result got %h want %h", meanOut, exp_full); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int de, bc, dc;
    setup_full();
    run(-10, 40, 1'b0, 0, de, bc, dc);
    vectors++;
    if (rst_mean !== '0) begin miscompares++; $display("FAIL rstmid_meanOut got %h want 0", rst_mean); end
    vectors++;
    if (rst_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", rst_busy); end
    vectors++;
    if (rst_done !== 1'b0 || dc !== 0) begin
      miscompares++; $display("FAIL rstmid_done got %b pulses %0d want 0 pulses 0", rst_done, dc);
    end
    idle(2);
    run(-10, -10, 1'b0, 0, de, bc, dc);
    vectors++;
    if (meanOut !== exp_full) begin miscompares++; $display("FAIL rstmid_rerun_result got %h want %h", meanOut, exp_full); end
    vectors++;
    if (de !== 161) begin miscompares++; $display("FAIL rstmid_rerun_done_edge got %0d want 161", de); end
    vectors++;
    if (snap10 !== 24'h0) begin miscompares++; $display("FAIL rstmid_slice0_before_store got %h want 0", snap10); end
    vectors++;
    if (snap11 !== exp_full[23:0]) begin miscompares++; $display("FAIL rstmid_slice0_after_store got %h want %h", snap11, exp_full[23:0]); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic_divide();
    test_merge();
    test_skip();
    test_full_load();
    test_start_during_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
